// File: rtl/switch_debouncer.sv
// switch_debouncer
// Per-bit conditioner for raw, asynchronous, bouncy pin inputs. Each bit is
// synchronised through two flops and then filtered by its own stability
// counter: a new level is accepted only after the synchronised input has
// differed from the current debounced level for STABLE consecutive cycles.
//
// Output contract: O is a registered level. RISE/FALL are registered,
// single-cycle strobes that qualify a change of O in the same cycle O first
// shows the new value. There is no back-pressure; a strobe is lost if the
// consumer does not sample it in that cycle. CHANGED is the OR of all strobes.
//
// Latency: with I held from just before edge 0, O updates at edge STABLE+1.
// Reset clears the synchroniser, counters, levels and strobes. A reset that
// drops O from 1 to 0 does not produce a FALL strobe.

module switch_debouncer #(
    parameter int WIDTH     = 5,
    parameter int STABLE    = 50000,
    parameter int CNT_WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHANGED
);

    // Terminal count: the counter value at which the next differing sample
    // completes a run of STABLE differing samples.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Reject parameter sets that the counter cannot represent.
    generate
        if (STABLE < 1) begin : g_bad_stable
            $error("switch_debouncer: STABLE must be at least 1");
        end
        if ((64'd1 << CNT_WIDTH) < 64'(STABLE)) begin : g_bad_cnt_width
            $error("switch_debouncer: CNT_WIDTH too small for STABLE");
        end
    endgenerate

    // Synchroniser stages; nothing sits between them.
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // One stability counter per bit; never exceeds STABLE-1.
    logic [CNT_WIDTH-1:0] cnt [WIDTH];

    // Two-flop synchroniser bringing the asynchronous pins into CLK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= I;
            s2 <= s1;
        end
    end

    // Per-bit filter: count consecutive cycles where s2 differs from O and
    // accept the new level (with a one-cycle strobe) at the terminal count.
    // Any cycle where s2 agrees with O discards the partial count.
    always_ff @(posedge CLK) begin
        for (int b = 0; b < WIDTH; b++) begin
            if (RESET) begin
                cnt[b]  <= '0;
                O[b]    <= 1'b0;
                RISE[b] <= 1'b0;
                FALL[b] <= 1'b0;
            end else if (s2[b] == O[b]) begin
                cnt[b]  <= '0;
                RISE[b] <= 1'b0;
                FALL[b] <= 1'b0;
            end else if (cnt[b] == CNT_LAST) begin
                O[b]    <= s2[b];
                cnt[b]  <= '0;
                RISE[b] <= s2[b];
                FALL[b] <= ~s2[b];
            end else begin
                cnt[b]  <= cnt[b] + CNT_ONE;
                RISE[b] <= 1'b0;
                FALL[b] <= 1'b0;
            end
        end
    end

    // Any-bit change indicator, derived only from registered strobes.
    always_comb begin
        CHANGED = |(RISE | FALL);
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer. Two instances share clock and reset: one with
// STABLE=4 and one with STABLE=1. A reference model evaluates, per edge, a
// window rule over the recorded input history: a bit flips when the last
// STABLE synchronised samples all differ from the current level and all come
// after the last flip/reset of that bit. Expected outputs are queued per edge
// and a monitor on the falling edge pops and compares.

module tb_switch_debouncer;

    localparam int W    = 5;
    localparam int OW   = 3 * W + 1;
    localparam int MAXC = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i4, i1;
    logic [W-1:0] o4, r4, f4, o1, r1, f1;
    logic         c4, c1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    switch_debouncer #(.WIDTH(W), .STABLE(4), .CNT_WIDTH(16)) dut4 (
        .CLK(clk), .RESET(rst), .I(i4),
        .O(o4), .RISE(r4), .FALL(f4), .CHANGED(c4)
    );

    switch_debouncer #(.WIDTH(W), .STABLE(1), .CNT_WIDTH(2)) dut1 (
        .CLK(clk), .RESET(rst), .I(i1),
        .O(o1), .RISE(r1), .FALL(f1), .CHANGED(c1)
    );

    // ---------------- reference model ----------------
    logic [W-1:0] ih [2][MAXC];   // input sampled at each edge
    logic         rh [MAXC];      // reset sampled at each edge
    logic [W-1:0] om [2];         // model debounced level
    int           last_ev [2][W]; // edge of last flip or reset per bit
    int           k = 0;
    logic [OW-1:0] exp_q4 [$];
    logic [OW-1:0] exp_q1 [$];
    logic [OW-1:0] e_tmp;

    initial begin
        for (int n = 0; n < 2; n++) begin
            om[n] = '0;
            for (int b = 0; b < W; b++) last_ev[n][b] = -1;
        end
    end

    // Synchronised value seen by the filter at edge j: the input from two
    // edges earlier, or 0 if either of the two preceding edges was a reset.
    function automatic logic [W-1:0] s2_at(input int n, input int j);
        if (j < 2) return '0;
        if (rh[j-1] || rh[j-2]) return '0;
        return ih[n][j-2];
    endfunction

    function automatic bit window_differs(input int n, input int s, input int kk, input int b);
        logic [W-1:0] v;
        for (int j = kk - s + 1; j <= kk; j++) begin
            if (j <= last_ev[n][b]) return 1'b0;
            v = s2_at(n, j);
            if (v[b] == om[n][b]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input int n, input int s, input int kk, output logic [OW-1:0] e);
        logic [W-1:0] rise, fall;
        rise = '0;
        fall = '0;
        if (rh[kk]) begin
            om[n] = '0;
            for (int b = 0; b < W; b++) last_ev[n][b] = kk;
        end else begin
            for (int b = 0; b < W; b++) begin
                if (window_differs(n, s, kk, b)) begin
                    om[n][b]      = ~om[n][b];
                    rise[b]       = om[n][b];
                    fall[b]       = ~om[n][b];
                    last_ev[n][b] = kk;
                end
            end
        end
        e = {om[n], rise, fall, |(rise | fall)};
    endtask

    always @(posedge clk) begin
        if (k < MAXC) begin
            ih[0][k] = i4;
            ih[1][k] = i1;
            rh[k]    = rst;
            model_edge(0, 4, k, e_tmp);
            exp_q4.push_back(e_tmp);
            model_edge(1, 1, k, e_tmp);
            exp_q1.push_back(e_tmp);
            k++;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int mon_edge = 0;
    always @(negedge clk) begin
        logic [OW-1:0] got, exp_v;
        if (exp_q4.size() > 0) begin
            exp_v = exp_q4.pop_front();
            got   = {o4, r4, f4, c4};
            tests++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL out_s4 edge %0d: got O=%b R=%b F=%b C=%b, expected O=%b R=%b F=%b C=%b",
                         mon_edge, got[15:11], got[10:6], got[5:1], got[0],
                         exp_v[15:11], exp_v[10:6], exp_v[5:1], exp_v[0]);
            end
        end
        if (exp_q1.size() > 0) begin
            exp_v = exp_q1.pop_front();
            got   = {o1, r1, f1, c1};
            tests++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL out_s1 edge %0d: got O=%b R=%b F=%b C=%b, expected O=%b R=%b F=%b C=%b",
                         mon_edge, got[15:11], got[10:6], got[5:1], got[0],
                         exp_v[15:11], exp_v[10:6], exp_v[5:1], exp_v[0]);
            end
        end
        mon_edge++;
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count rising edges from now until RISE[b] of the chosen instance is
    // seen; the edge at which O changes is included in the count.
    task automatic measure_rise(input int n, input int b, input int want, input string name);
        int  e;
        bit  seen;
        e    = 0;
        seen = 1'b0;
        while (e < 30 && !seen) begin
            @(posedge clk);
            e++;
            #1;
            seen = (n == 0) ? r4[b] : r1[b];
        end
        tests++;
        if (!seen || e != want) begin
            fails++;
            $display("FAIL %s: rise seen=%0b after %0d edges, expected after %0d", name, seen, e, want);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        i4  = '0;
        i1  = '0;
        cycles(2);
        rst = 1'b0;
        cycles(4);

        // Step on bit 0: visible after STABLE+2 edges.
        i4 = 5'b00001;
        measure_rise(0, 0, 6, "latency_s4_bit0");
        @(negedge clk);
        i4 = 5'b00000;
        cycles(10);

        // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted.
        i4[2] = 1'b1;
        cycles(3);
        i4[2] = 1'b0;
        cycles(8);
        i4[2] = 1'b1;
        cycles(4);
        i4[2] = 1'b0;
        cycles(10);

        // Bounce on bit 3, then hold high.
        i4[3] = 1'b1; cycles(1);
        i4[3] = 1'b0; cycles(1);
        i4[3] = 1'b1; cycles(1);
        i4[3] = 1'b0; cycles(1);
        i4[3] = 1'b1;
        measure_rise(0, 3, 6, "bounce_s4_bit3");
        cycles(3);

        // Simultaneous multi-bit transition from O=00011.
        i4 = 5'b00011;
        cycles(12);
        i4 = 5'b11100;
        begin
            int  t;
            bit  hit;
            t   = 0;
            hit = 1'b0;
            while (t < 20 && !hit) begin
                @(negedge clk);
                t++;
                hit = c4;
            end
            tests++;
            if (!hit || {o4, r4, f4} !== {5'b11100, 5'b11100, 5'b00011}) begin
                fails++;
                $display("FAIL simultaneous: hit=%0b O=%b R=%b F=%b, expected O=11100 R=11100 F=00011",
                         hit, o4, r4, f4);
            end
            @(negedge clk);
            tests++;
            if ({r4, f4, c4} !== '0) begin
                fails++;
                $display("FAIL strobes_clear: R=%b F=%b C=%b, expected all 0", r4, f4, c4);
            end
        end

        // Reset mid-count on bit 4.
        i4 = 5'b00000;
        cycles(10);
        i4 = 5'b10000;
        cycles(4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        measure_rise(0, 4, 6, "reset_midcount_bit4");
        cycles(2);
        // Reset while O[4]=1: O drops without a FALL strobe.
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(10);

        // STABLE=1 corner: step latency, then a 1-cycle pulse.
        @(negedge clk);
        i1 = 5'b00001;
        measure_rise(1, 0, 3, "latency_s1_bit0");
        @(negedge clk);
        i1 = 5'b00000;
        cycles(6);
        i1[0] = 1'b1;
        cycles(1);
        i1[0] = 1'b0;
        begin
            int t;
            bit hit;
            t   = 0;
            hit = 1'b0;
            while (t < 10 && !hit) begin
                @(negedge clk);
                t++;
                hit = r1[0];
            end
            tests++;
            if (!hit || o1[0] !== 1'b1) begin
                fails++;
                $display("FAIL pulse_s1_rise: seen=%0b O0=%b, expected rise with O0=1", hit, o1[0]);
            end
            @(negedge clk);
            tests++;
            if ({f1[0], r1[0], o1[0]} !== 3'b100) begin
                fails++;
                $display("FAIL pulse_s1_fall: F0=%b R0=%b O0=%b, expected F0=1 R0=0 O0=0",
                         f1[0], r1[0], o1[0]);
            end
        end
        cycles(4);

        // Randomised phase with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) i4[b] = ~i4[b];
                if ($urandom_range(0, 2) == 0) i1[b] = ~i1[b];
            end
            rst = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        cycles(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
